// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared types and helpers for the sequential multiplier: the
//            controller state encoding and the latency formula used by both
//            the design and its bench.
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Controller states: capture, partial products, last accumulate, output
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Cycles from the start-accept cycle to the done cycle for K slices
  function automatic int lat(input int k);
    return k * k + 3;
  endfunction

  // $clog2 clamped to at least one bit so degenerate sizes still give a
  // legal vector width
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_part.sv
`default_nettype none
// ============================================================================
// Module   : mult_part
// Purpose  : Combinational PART x PART unsigned multiplier with a full-width
//            2*PART product. Sized to map onto a single DSP block.
// Revision : 1.0 - initial release
// ============================================================================
module mult_part #(
  parameter int PART = 16
) (
  input  logic [PART-1:0]   a_i,
  input  logic [PART-1:0]   b_i,
  output logic [2*PART-1:0] p_o
);

  // Both operands are zero-extended so the product is formed at full width
  assign p_o = {{PART{1'b0}}, a_i} * {{PART{1'b0}}, b_i};

endmodule
`default_nettype wire

// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq
// Purpose  : WIDTH x WIDTH multi-cycle multiplier that time-shares a single
//            PART x PART unsigned multiplier over all K*K partial products
//            (K = WIDTH/PART). start/busy/done handshake, latency K*K+3.
//            Optional two's-complement mode when MULT_SIGNED_EN is defined
//            (adds the signed_mode_i port); default build is unsigned only.
// Revision : 1.0 - initial release
// ============================================================================
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PART  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   dataa_i,
  input  logic [WIDTH-1:0]   datab_i,
`ifdef MULT_SIGNED_EN
  input  logic               signed_mode_i,
`endif
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int K         = WIDTH / PART;
  localparam int NPP       = K * K;
  localparam int RES_W     = 2 * WIDTH;
  localparam int IDX_W     = clog2_min1(NPP);
  localparam int SL_W      = clog2_min1(K);
  localparam int SHIFT_MAX = 2 * (K - 1) * PART;
  localparam int SHIFT_W   = clog2_min1(SHIFT_MAX + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPP - 1);

  // Reject operand widths that do not split into whole PART slices
  generate
    if ((PART < 1) || (WIDTH < PART) || ((WIDTH % PART) != 0)) begin : g_bad_width
      $error("mult_seq: WIDTH must be a positive integer multiple of PART");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [WIDTH-1:0]    a_mag_q;
  logic [WIDTH-1:0]    b_mag_q;
  logic [2*PART-1:0]   prod_q;
  logic [SHIFT_W-1:0]  shift_q;
  logic                pv_q;
  logic [RES_W-1:0]    acc_q;
  logic                busy_q;
  logic                done_q;
  logic [RES_W-1:0]    result_q;

  // --------------------------------------------------------------------------
  // Next-state / combinational helpers
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]    a_mag_d;
  logic [WIDTH-1:0]    b_mag_d;
  logic [SL_W-1:0]     slice_i;
  logic [SL_W-1:0]     slice_j;
  logic [PART-1:0]     part_a;
  logic [PART-1:0]     part_b;
  logic [2*PART-1:0]   part_p;
  logic [SHIFT_W-1:0]  shift_d;
  logic [RES_W-1:0]    acc_d;
  logic [RES_W-1:0]    result_d;

`ifdef MULT_SIGNED_EN
  logic sign_q;
  logic sign_d;
  logic a_neg;
  logic b_neg;

  // In signed mode each negative operand is replaced by its magnitude; the
  // magnitude of the most negative value still fits unsigned in WIDTH bits.
  assign a_neg   = signed_mode_i & dataa_i[WIDTH-1];
  assign b_neg   = signed_mode_i & datab_i[WIDTH-1];
  assign sign_d  = a_neg ^ b_neg;
  assign a_mag_d = a_neg ? (WIDTH'(0) - dataa_i) : dataa_i;
  assign b_mag_d = b_neg ? (WIDTH'(0) - datab_i) : datab_i;

  // Restore the sign of the product once the magnitude is complete
  assign result_d = sign_q ? (RES_W'(0) - acc_q) : acc_q;
`else
  assign a_mag_d  = dataa_i;
  assign b_mag_d  = datab_i;
  assign result_d = acc_q;
`endif

  // idx walks the partial products row by row: i selects the a slice, j the
  // b slice.
  assign slice_i = SL_W'(32'(idx_q) / K);
  assign slice_j = SL_W'(32'(idx_q) % K);
  assign part_a  = a_mag_q[slice_i * PART +: PART];
  assign part_b  = b_mag_q[slice_j * PART +: PART];
  assign shift_d = SHIFT_W'((32'(slice_i) + 32'(slice_j)) * PART);

  // Accumulator input: previous partial product placed at its bit weight
  assign acc_d = acc_q + (RES_W'(prod_q) << shift_q);

  mult_part #(
    .PART (PART)
  ) u_part (
    .a_i (part_a),
    .b_i (part_b),
    .p_o (part_p)
  );

  // Operand magnitudes are captured only when a request is accepted
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && start_i) begin
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
    end
  end

  // Controller, partial-product pipeline, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      prod_q   <= '0;
      shift_q  <= '0;
      pv_q     <= 1'b0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef MULT_SIGNED_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      pv_q   <= 1'b0;
      // A registered partial product is folded in on the edge after it forms
      if (pv_q) begin
        acc_q <= acc_d;
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= MUL;
            idx_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
`ifdef MULT_SIGNED_EN
            sign_q  <= sign_d;
`endif
          end
        end
        MUL: begin
          prod_q  <= part_p;
          shift_q <= shift_d;
          pv_q    <= 1'b1;
          if (idx_q == IDX_LAST) begin
            state_q <= ACC;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ACC: begin
          // Last partial product is added on this edge
          state_q <= FIX;
        end
        FIX: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mult_seq
// Purpose  : Self-checking bench for mult_seq. Drives a 32/16 and a 48/16
//            instance; checks table vectors, handshake timing corner cases
//            and random operands against an arithmetic reference model.
//            Signed vectors are included when MULT_SIGNED_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_seq;
  import mult_pkg::*;

  localparam int L32 = lat(2);
  localparam int L48 = lat(3);

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        st32  = 1'b0;
  logic        st48  = 1'b0;
  logic [31:0] a32   = '0;
  logic [31:0] b32   = '0;
  logic [47:0] a48   = '0;
  logic [47:0] b48   = '0;
`ifdef MULT_SIGNED_EN
  logic        sm32  = 1'b0;
  logic        sm48  = 1'b0;
`endif
  logic        busy32, done32, busy48, done48;
  logic [63:0] res32;
  logic [95:0] res48;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          w48;
    logic [47:0] a;
    logic [47:0] b;
    logic        sm;
    logic [95:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mult_seq #(.WIDTH(32), .PART(16)) dut32 (
    .clk           (clk),
    .reset         (reset),
    .start_i       (st32),
    .dataa_i       (a32),
    .datab_i       (b32),
`ifdef MULT_SIGNED_EN
    .signed_mode_i (sm32),
`endif
    .busy_o        (busy32),
    .done_o        (done32),
    .result_o      (res32)
  );

  mult_seq #(.WIDTH(48), .PART(16)) dut48 (
    .clk           (clk),
    .reset         (reset),
    .start_i       (st48),
    .dataa_i       (a48),
    .datab_i       (b48),
`ifdef MULT_SIGNED_EN
    .signed_mode_i (sm48),
`endif
    .busy_o        (busy48),
    .done_o        (done48),
    .result_o      (res48)
  );

  // Reference: sign- or zero-extend to 96 bits, multiply, keep 2*W bits
  function automatic logic [95:0] model(input bit w48, input logic [47:0] a,
                                        input logic [47:0] b, input logic sm);
    logic [95:0] ax, bx, p;
    logic        s;
    s = sm;
`ifndef MULT_SIGNED_EN
    s = 1'b0;
`endif
    if (w48) begin
      ax = s ? {{48{a[47]}}, a} : {48'b0, a};
      bx = s ? {{48{b[47]}}, b} : {48'b0, b};
      p  = ax * bx;
    end else begin
      ax = s ? {{64{a[31]}}, a[31:0]} : {64'b0, a[31:0]};
      bx = s ? {{64{b[31]}}, b[31:0]} : {64'b0, b[31:0]};
      p  = ax * bx;
      p[95:64] = '0;
    end
    return p;
  endfunction

  function automatic logic [95:0] rd_res(input bit w48);
    return w48 ? res48 : {32'b0, res32};
  endfunction
  function automatic logic rd_busy(input bit w48);
    return w48 ? busy48 : busy32;
  endfunction
  function automatic logic rd_done(input bit w48);
    return w48 ? done48 : done32;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_start(input bit w48, input logic v);
    if (w48) st48 = v; else st32 = v;
  endtask

  task automatic set_ops(input bit w48, input logic [47:0] a, input logic [47:0] b,
                         input logic sm);
    if (w48) begin a48 = a; b48 = b; end
    else begin a32 = a[31:0]; b32 = b[31:0]; end
`ifdef MULT_SIGNED_EN
    if (w48) sm48 = sm; else sm32 = sm;
`else
    if (sm) begin end
`endif
  endtask

  // Present a request in the current cycle (cycle 0)
  task automatic issue(input bit w48, input logic [47:0] a, input logic [47:0] b,
                       input logic sm);
    set_ops(w48, a, b, sm);
    set_start(w48, 1'b1);
  endtask

  // Step cycles 1..latency, checking busy/done each cycle, result held until
  // the done cycle and correct in it. Operands are scrambled after accept;
  // ignore_at>0 pulses start with other operands in that cycle.
  task automatic run(input bit w48, input logic [95:0] exp, input string name,
                     input int ignore_at);
    int          lcy;
    logic [95:0] held;
    lcy  = w48 ? L48 : L32;
    held = rd_res(w48);
    for (int c = 1; c <= lcy; c++) begin
      step();
      if (c == 1) begin
        set_start(w48, 1'b0);
        set_ops(w48, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom()));
      end
      if (ignore_at > 0 && c == ignore_at) begin
        set_ops(w48, 48'h5555_0000_7777, 48'h0000_3333_1111, 1'b0);
        set_start(w48, 1'b1);
      end
      if (ignore_at > 0 && c == ignore_at + 1) set_start(w48, 1'b0);
      chk($sformatf("%s busy c%0d", name, c), 96'(rd_busy(w48)), 96'(c < lcy));
      chk($sformatf("%s done c%0d", name, c), 96'(rd_done(w48)), 96'(c == lcy));
      if (c < lcy) chk($sformatf("%s held c%0d", name, c), rd_res(w48), held);
      else         chk($sformatf("%s result", name), rd_res(w48), exp);
    end
  endtask

  // Quiet cycles: no done, not busy, result unchanged
  task automatic idle(input bit w48, input int n, input string name);
    logic [95:0] held;
    held = rd_res(w48);
    for (int c = 0; c < n; c++) begin
      step();
      chk($sformatf("%s idle done", name), 96'(rd_done(w48)), 96'(0));
      chk($sformatf("%s idle busy", name), 96'(rd_busy(w48)), 96'(0));
      chk($sformatf("%s idle res", name), rd_res(w48), held);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [47:0] ra, rb;
    logic        rsm;
    bit          rw;

    // ---- table -----------------------------------------------------------
    vecs.push_back('{1'b0, 48'hFFFFFFFF, 48'hFFFFFFFF, 1'b0, 96'h0000_0000_0000_0000_FFFF_FFFE_0000_0001});
    vecs.push_back('{1'b0, 48'h80000000, 48'h80000000, 1'b0, 96'h4000_0000_0000_0000});
    vecs.push_back('{1'b0, 48'hFFFFFFFD, 48'h00000005, 1'b0, 96'h0000_0004_FFFF_FFF1});
    vecs.push_back('{1'b0, 48'h12345678, 48'h9ABCDEF0, 1'b0, 96'h0B00_EA4E_242D_2080});
    vecs.push_back('{1'b0, 48'h00000000, 48'hFFFFFFFF, 1'b0, 96'h0});
    vecs.push_back('{1'b0, 48'h00000001, 48'h00000001, 1'b0, 96'h1});
    vecs.push_back('{1'b0, 48'h00010000, 48'h00010000, 1'b0, 96'h1_0000_0000});
    vecs.push_back('{1'b1, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b0, 96'hFFFF_FFFF_FFFE_0000_0000_0001});
    vecs.push_back('{1'b1, 48'h000000000001, 48'hFFFFFFFFFFFF, 1'b0, 96'h0000_0000_0000_FFFF_FFFF_FFFF});
`ifdef MULT_SIGNED_EN
    vecs.push_back('{1'b0, 48'hFFFFFFFD, 48'h00000005, 1'b1, 96'hFFFF_FFFF_FFFF_FFF1});
    vecs.push_back('{1'b0, 48'h80000000, 48'h80000000, 1'b1, 96'h4000_0000_0000_0000});
    vecs.push_back('{1'b0, 48'h80000000, 48'h7FFFFFFF, 1'b1, 96'hC000_0000_8000_0000});
    vecs.push_back('{1'b1, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b1, 96'h1});
    vecs.push_back('{1'b1, 48'hFFFFFFFFFFFF, 48'h000000000001, 1'b1, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF});
`endif

    // ---- reset state -----------------------------------------------------
    step();
    step();
    chk("reset busy32", 96'(busy32), 96'(0));
    chk("reset done32", 96'(done32), 96'(0));
    chk("reset res32",  {32'b0, res32}, 96'(0));
    chk("reset busy48", 96'(busy48), 96'(0));
    chk("reset done48", 96'(done48), 96'(0));
    chk("reset res48",  res48, 96'(0));
    reset = 1'b0;
    step();

    // ---- table vectors ---------------------------------------------------
    foreach (vecs[k]) begin
      issue(vecs[k].w48, vecs[k].a, vecs[k].b, vecs[k].sm);
      run(vecs[k].w48, vecs[k].exp, $sformatf("vec%0d", k), 0);
      idle(vecs[k].w48, 1, $sformatf("vec%0d", k));
    end

    // ---- start during an operation is ignored ----------------------------
    issue(1'b0, 48'h0000FFFF, 48'h00010001, 1'b0);
    run(1'b0, 96'h0000_0000_FFFF_FFFF, "ignore_start", 3);
    idle(1'b0, L32 + 2, "ignore_start");

    // ---- back-to-back: start in the done cycle ---------------------------
    issue(1'b0, 48'hFFFFFFFF, 48'hFFFFFFFF, 1'b0);
    run(1'b0, 96'hFFFF_FFFE_0000_0001, "b2b_first", 0);
    issue(1'b0, 48'h12345678, 48'h9ABCDEF0, 1'b0);
    run(1'b0, 96'h0B00_EA4E_242D_2080, "b2b_second", 0);
    idle(1'b0, 2, "b2b");

    // ---- reset in cycle 4 of an operation --------------------------------
    issue(1'b0, 48'hDEADBEEF, 48'h00001234, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) st32 = 1'b0;
      chk($sformatf("rst_mid busy c%0d", c), 96'(busy32), 96'(1));
    end
    reset = 1'b1;
    step();
    chk("rst_mid busy after", 96'(busy32), 96'(0));
    chk("rst_mid done after", 96'(done32), 96'(0));
    chk("rst_mid res after",  {32'b0, res32}, 96'(0));
    reset = 1'b0;
    idle(1'b0, L32 + 2, "rst_mid");
    issue(1'b0, 48'h2, 48'h3, 1'b0);
    run(1'b0, 96'h6, "rst_then_2x3", 0);
    idle(1'b0, 1, "rst_then_2x3");

    // ---- random operands against the reference model --------------------
    for (int n = 0; n < 30; n++) begin
      rw  = (n % 3 == 2);
      ra  = 48'({$urandom(), $urandom()});
      rb  = 48'({$urandom(), $urandom()});
      rsm = 1'($urandom_range(0, 1));
      if (n % 5 == 0) ra = rw ? 48'h8000_0000_0000 : 48'h0000_8000_0000;
      if (n % 7 == 0) rb = rw ? 48'hFFFF_FFFF_FFFF : 48'h0000_FFFF_FFFF;
      issue(rw, ra, rb, rsm);
      run(rw, model(rw, ra, rb, rsm), $sformatf("rand%0d", n), 0);
    end
    idle(1'b0, 1, "final32");
    idle(1'b1, 1, "final48");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
